serial_tx: RTL and testbench
============================

// Module: serial_tx
//
// PURPOSE
//   Parallel-in/serial-out transmitter: accepts a DATA_W-bit word on a valid/ready
//   handshake and drives it out one bit per clk, with a per-bit valid strobe and an
//   end-of-frame marker.
//   Counterpart to the capture flops elsewhere in this codebase: the bit-serial source
//   feeding a downstream sampling/shift-in stage.
//
// PARAMETERS
//   DATA_W     8   word width in bits (>=2)
//   LSB_FIRST  1   1: bit 0 is sent first; 0: bit DATA_W-1 is sent first
//
// PORTS
//   clk          in   1       clock, all state updates on posedge
//   reset        in   1       reset, asynchronous assert, active-low (0 = in reset)
//   in_valid_i   in   1       upstream word valid
//   in_data_i    in   DATA_W  upstream word, sampled only on handshake
//   in_ready_o   out  1       block can accept a word this cycle
//   ser_o        out  1       serial data bit
//   ser_valid_o  out  1       ser_o carries a frame bit this cycle
//   ser_last_o   out  1       final bit of current frame
//   busy_o       out  1       frame in progress (== ser_valid_o)
//
// BEHAVIOUR
//   - Reset (reset=0): all outputs 0 immediately (async), including in_ready_o;
//     state=IDLE, shift reg and bit counter cleared. In-flight frame discarded, never resumed.
//   - All outputs are registered; no combinational path from inputs to outputs.
//   - in_ready_o goes 1 on the first clk edge after reset deasserts.
//   - Handshake: word accepted on a posedge with in_valid_i & in_ready_o = 1.
//     in_valid_i/in_data_i are ignored whenever in_ready_o = 0.
//   - FSM: IDLE -> SHIFT on accept; SHIFT -> (PARITY if enabled) -> IDLE, or
//     SHIFT -> SHIFT on a back-to-back accept.
//   - Latency: first bit is on ser_o in the cycle after accept (1 clk). A frame occupies
//     exactly DATA_W consecutive cycles with ser_valid_o=1; ser_last_o=1 only in the last one.
//   - Bit counter counts 0..DATA_W-1 ($clog2(DATA_W) bits); no wrap inside a frame.
//   - in_ready_o = 1 in IDLE and during the final frame cycle (ser_last_o=1); 0 otherwise.
//     Accept in the final cycle starts the next frame with no gap (100% bit throughput).
//   - Final cycle with in_valid_i=0: next cycle IDLE; ser_valid_o=0, ser_o=0, ser_last_o=0.
//   - Idle: ser_o=0, ser_valid_o=0, ser_last_o=0, busy_o=0.
//   - Reset while in_valid_i=1: no accept until ready rises after release.
//
// CONFIGURATION
//   SERIAL_TX_PARITY_EN
//     Defined: one even-parity bit (^word) is appended after the data bits.
//       - Frame length is DATA_W+1 cycles.
//       - ser_last_o and in_ready_o move to the parity cycle; the PARITY state is used.
//     Undefined: no parity; frame length DATA_W; PARITY state not built.
//
// TESTING
//   1 Reset: hold reset=0 for 3 clk with in_valid_i=1 -> all outputs 0; release ->
//     in_ready_o=1 after 1st edge, no word taken before that.
//   2 Single word: DATA_W=8, LSB_FIRST=1, send 0xA5 -> ser_o=1,0,1,0,0,1,0,1 on cycles
//     1..8, ser_last_o on cycle 8, ser_valid_o=0 on cycle 9. LSB_FIRST=0 -> 1,0,1,0,0,1,0,1
//     (0xA5 is a palindrome); repeat with 0x01 -> seven 0s then a 1.
//   3 Back-to-back: 0x0F then 0xF0 with in_valid_i held -> 16 contiguous valid bits
//     1111_0000_0000_1111, ser_last_o at bits 8 and 16, no idle gap.
//   4 Backpressure: in_valid_i=1 with 0xFF during bits 2..6 of frame 0x00 -> ignored,
//     eight 0 bits out; word 0xFF accepted only at the ser_last_o cycle.
//   5 Mid-frame reset: reset=0 after bit 3 of 0xAA -> outputs 0 asynchronously; after
//     release send 0x01 -> exact 8-bit frame, no residue of 0xAA.
//   6 SERIAL_TX_PARITY_EN: 0x07 -> 9 bits, 9th=1, ser_last_o on 9th; 0x03 -> 9th=0;
//     back-to-back accept occurs in the parity cycle.

Source files
------------

// File: rtl/serial_tx.sv
// Parallel-in/serial-out transmitter: one DATA_W-bit word per valid/ready handshake,
// shifted out one bit per clk. Optional even-parity bit via SERIAL_TX_PARITY_EN.
module serial_tx #(
    parameter int DATA_W    = 8,
    parameter int LSB_FIRST = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              in_ready_o,
    output logic              ser_o,
    output logic              ser_valid_o,
    output logic              ser_last_o,
    output logic              busy_o
);
    localparam int CW = $clog2(DATA_W);
    localparam logic [CW-1:0] CNT_MAX = CW'(DATA_W - 1);

`ifdef SERIAL_TX_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
    typedef enum logic [0:0] {IDLE, SHIFT} state_t;
`endif

    state_t            state, state_n;
    logic [DATA_W-1:0] sh, sh_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic              ser_q, ser_n;
    logic              valid_q, valid_n;
    logic              last_q, last_n;
    logic              ready_q, ready_n;
    logic              frame_end;
    logic              accept;
`ifdef SERIAL_TX_PARITY_EN
    logic              par, par_n;
`endif

    assign accept = in_valid_i & ready_q;

    // Bit currently on the wire sits at a fixed end of the shift register.
    function automatic logic head(input logic [DATA_W-1:0] w);
        return (LSB_FIRST != 0) ? w[0] : w[DATA_W-1];
    endfunction

    function automatic logic [DATA_W-1:0] adv(input logic [DATA_W-1:0] w);
        return (LSB_FIRST != 0) ? (w >> 1) : (w << 1);
    endfunction

    always_comb begin
        state_n   = state;
        sh_n      = sh;
        cnt_n     = cnt;
        ser_n     = 1'b0;
        valid_n   = 1'b0;
        last_n    = 1'b0;
        ready_n   = 1'b0;
        frame_end = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
        par_n     = par;
`endif
        case (state)
            IDLE: frame_end = 1'b1;
            SHIFT: begin
                if (cnt != CNT_MAX) begin
                    sh_n    = adv(sh);
                    cnt_n   = cnt + CW'(1);
                    ser_n   = head(sh_n);
                    valid_n = 1'b1;
`ifdef SERIAL_TX_PARITY_EN
                    last_n  = 1'b0;
`else
                    last_n  = (cnt_n == CNT_MAX);
`endif
                    ready_n = last_n;
                end else begin
`ifdef SERIAL_TX_PARITY_EN
                    state_n = PARITY;
                    ser_n   = par;
                    valid_n = 1'b1;
                    last_n  = 1'b1;
                    ready_n = 1'b1;
`else
                    frame_end = 1'b1;
`endif
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            PARITY: frame_end = 1'b1;
`endif
            default: state_n = IDLE;
        endcase

        // Last frame cycle (or idle): chain the next word with no gap, else go idle.
        if (frame_end) begin
            if (accept) begin
                state_n = SHIFT;
                sh_n    = in_data_i;
                cnt_n   = '0;
                ser_n   = head(in_data_i);
                valid_n = 1'b1;
                last_n  = 1'b0;
                ready_n = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
                par_n   = ^in_data_i;
`endif
            end else begin
                state_n = IDLE;
                ready_n = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            sh      <= '0;
            cnt     <= '0;
            ser_q   <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            ready_q <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            par     <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            sh      <= sh_n;
            cnt     <= cnt_n;
            ser_q   <= ser_n;
            valid_q <= valid_n;
            last_q  <= last_n;
            ready_q <= ready_n;
`ifdef SERIAL_TX_PARITY_EN
            par     <= par_n;
`endif
        end
    end

    assign in_ready_o  = ready_q;
    assign ser_o       = ser_q;
    assign ser_valid_o = valid_q;
    assign ser_last_o  = last_q;
    assign busy_o      = valid_q;

endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: LSB-first and MSB-first instances on shared inputs, checked
// every cycle against a queue-of-frame-bits reference model.
module tb_serial_tx;
    localparam int W = 8;
`ifdef SERIAL_TX_PARITY_EN
    localparam int FL = W + 1;
`else
    localparam int FL = W;
`endif

    typedef struct packed {
        logic bl;
        logic bm;
        logic last;
    } ent_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_data = '0;
    logic [1:0]   rdy, ser, sv, sl, busy;

    ent_t q[$];
    bit   started = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   cyc = 0;

    always #5 clk = ~clk;

    serial_tx #(.DATA_W(W), .LSB_FIRST(1)) u_lsb (
        .clk(clk), .reset(reset), .in_valid_i(in_valid), .in_data_i(in_data),
        .in_ready_o(rdy[0]), .ser_o(ser[0]), .ser_valid_o(sv[0]),
        .ser_last_o(sl[0]), .busy_o(busy[0]));

    serial_tx #(.DATA_W(W), .LSB_FIRST(0)) u_msb (
        .clk(clk), .reset(reset), .in_valid_i(in_valid), .in_data_i(in_data),
        .in_ready_o(rdy[1]), .ser_o(ser[1]), .ser_valid_o(sv[1]),
        .ser_last_o(sl[1]), .busy_o(busy[1]));

    task automatic chk(input string tag, input logic [1:0] got, input logic [1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%b exp=%b", tag, cyc, got, exp);
        end
    endtask

    // Model: the queue holds the remaining bits of the current frame, front = on the wire.
    task automatic model_edge();
        ent_t e;
        bit   acc;
        acc = in_valid && started && (q.size() <= 1);
        if (q.size() > 0) void'(q.pop_front());
        if (acc) begin
            for (int i = 0; i < W; i++) begin
                e.bl   = in_data[i];
                e.bm   = in_data[W-1-i];
                e.last = (i == FL - 1);
                q.push_back(e);
            end
`ifdef SERIAL_TX_PARITY_EN
            e.bl   = ^in_data;
            e.bm   = ^in_data;
            e.last = 1'b1;
            q.push_back(e);
`endif
        end
        started = 1'b1;
    endtask

    task automatic check_outs();
        logic [1:0] es, ev, el, er;
        if (q.size() > 0) begin
            es = {q[0].bm, q[0].bl};
            ev = 2'b11;
            el = {2{q[0].last}};
        end else begin
            es = 2'b00;
            ev = 2'b00;
            el = 2'b00;
        end
        er = {2{started && (q.size() <= 1)}};
        chk("in_ready", rdy, er);
        chk("ser", ser, es);
        chk("ser_valid", sv, ev);
        chk("ser_last", sl, el);
        chk("busy", busy, ev);
    endtask

    task automatic step(input bit v, input logic [W-1:0] d);
        in_valid = v;
        in_data  = d;
        @(posedge clk);
        cyc++;
        if (reset) model_edge();
        #1;
        check_outs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00);
    endtask

    // Asynchronous reset between edges, checked before the next edge arrives.
    task automatic async_reset(input int hold);
        #3;
        reset = 1'b0;
        q.delete();
        started = 1'b0;
        #1;
        check_outs();
        for (int i = 0; i < hold; i++) step(1'b1, 8'hC3);
        reset = 1'b1;
        #1;
        check_outs();
    endtask

    initial begin
        // Reset with valid held high: nothing accepted until ready has risen.
        in_valid = 1'b1;
        in_data  = 8'h5A;
        #2;
        reset = 1'b0;
        #1;
        check_outs();
        for (int i = 0; i < 3; i++) step(1'b1, 8'h5A);
        reset = 1'b1;
        step(1'b1, 8'h5A);
        step(1'b1, 8'h5A);
        idle(FL + 1);

        step(1'b1, 8'hA5);
        idle(FL + 1);
        step(1'b1, 8'h01);
        idle(FL + 1);

        // Back-to-back with valid held across the frame.
        step(1'b1, 8'h0F);
        for (int i = 0; i < FL; i++) step(1'b1, 8'hF0);
        idle(FL + 1);

        // Backpressure: 0xFF offered mid-frame, taken only at the last bit.
        step(1'b1, 8'h00);
        step(1'b0, 8'h00);
        for (int i = 0; i < FL; i++) step(1'b1, 8'hFF);
        idle(FL + 1);

        // Mid-frame reset, then a clean frame.
        step(1'b1, 8'hAA);
        idle(3);
        async_reset(2);
        idle(1);
        step(1'b1, 8'h01);
        idle(FL + 1);

        step(1'b1, 8'h07);
        for (int i = 0; i < FL; i++) step(1'b1, 8'h03);
        idle(FL + 1);

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) async_reset($urandom_range(0, 2));
            else step($urandom_range(0, 3) != 0, W'($urandom));
        end
        idle(FL + 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
